mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised, registered successor to the combinational 3-input select mux used in the y86 datapath.
- Selects one of N signed WIDTH-bit operands by binary select.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput under backpressure.
- Used between the forwarding-select logic and the execute-stage operand latch. Flags out-of-range selects.

Parameters:
WIDTH, 64, data width per input/output (signed, two's complement)
N, 3, number of data inputs (2..16)
SEL_W, $clog2(N) (2 for N=3), select width; derived, do not override

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
in_data  input  N*WIDTH  packed operands; input k at bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  binary select, valid with in_valid
in_valid  input  1  upstream offers in_data/in_sel
in_ready  output  1  block can accept this cycle
out_data  output  WIDTH  selected operand (registered)
out_valid  output  1  out_data holds an unconsumed result
out_ready  input  1  downstream accepts out_data this cycle
sel_err  output  1  sticky: an accepted transfer had in_sel >= N
occ  output  2  current occupancy, 0..2

Behaviour:
- Clocking/reset: one clock domain. Reset is synchronous and active-low: clk, rst_n.
- Values while rst_n=0 and on the first cycle after release:
  - out_valid=0, out_data=0, sel_err=0, occ=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first cycle after rst_n=1.
- Transfers:
  - Accept = in_valid && in_ready.
  - Emit = out_valid && out_ready.
- Selection (combinational, at accept):
  - val = in_data[in_sel*WIDTH +: WIDTH] when in_sel < N.
  - val = 0 when in_sel >= N; also sets sel_err=1, which holds until reset.
- State machine on occupancy:
  - EMPTY (occ=0): out_valid=0, in_ready=1.
    - Accept -> out reg=val, go ONE.
  - ONE (occ=1): out_valid=1, in_ready=1.
    - Accept && Emit -> out reg=val, stay ONE.
    - Accept && !Emit -> skid=val, go TWO.
    - !Accept && Emit -> go EMPTY (out_data keeps its last value).
    - Neither -> hold.
  - TWO (occ=2): out_valid=1, in_ready=0.
    - Emit -> out reg=skid, go ONE.
    - No Emit -> hold.
- Latency: accept in cycle t -> out_valid with the selected value in cycle t+1 (from EMPTY or ONE-with-emit).
- Throughput: 1 transfer/clk while out_ready=1.
- Ordering: strict FIFO, no drop, no duplication.
- Stability: out_data/out_valid never change while out_valid=1 && out_ready=0.
- in_ready depends only on registered state. No combinational path from out_ready to in_ready.
- Reset mid-operation: any occupancy is discarded; outputs return to reset values on the next edge.
- in_valid is ignored while in_ready=0; the upstream must hold its data.

Optional Feature:
- Macro MUX_N_PIPE_XFER_CNT_EN.
- With it defined:
  - Extra output xfer_cnt, 16 bits, counts Emit events.
  - Saturates at 16'hFFFF; reset value 0.
  - Clears synchronously when rst_n=0.
- Without it: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with in_valid=1 -> out_valid=0, in_ready=0, out_data=0, occ=0, sel_err=0 throughout; in_ready=1 on the cycle after release.
- Streaming, WIDTH=64, N=3, out_ready=1:
  - Operands X0=1, X1=-2, X2=3.
  - in_sel 2,1,0 on consecutive cycles -> out_data 3, -2, 1 on cycles t+1..t+3.
  - out_valid stays high for 3 cycles; occ stays at 1.
- Backpressure: out_ready=0, accept sel=0 then sel=1 (X0=1, X1=-2):
  - occ=2, in_ready=0; out_data=1 held stable.
  - Raise out_ready -> emits 1 then -2, occ 2->1->0.
  - A third in_valid offered while full is not accepted.
- Out-of-range: in_sel=3 with N=3 -> out_data=0, sel_err=1; sel_err remains 1 after later valid selects, clears only on rst_n=0.
- Reset mid-operation: with occ=2, assert rst_n=0 for 1 clk -> next cycle out_valid=0, occ=0; neither buffered value is ever emitted.
- Counter (MUX_N_PIPE_XFER_CNT_EN defined): 5 emits -> xfer_cnt=5; forced to 16'hFFFF, one more emit -> stays 16'hFFFF.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N-input signed operand select with a 2-entry skid
// buffer behind a valid/ready handshake. Sits between the forwarding-select
// logic and the execute-stage operand latch.
//
// Out-of-range selects deliver zero and raise a sticky sel_err flag.
// in_ready is driven from registered state only, so there is no combinational
// path from out_ready back to in_ready.
//
// Optional build macro: MUX_N_PIPE_XFER_CNT_EN adds the output port xfer_cnt.
// xfer_cnt is a 16-bit saturating count of output transfers.
module mux_n_pipe #(
    parameter int WIDTH = 64,
    parameter int N     = 3,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N*WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [1:0]              occ
`ifdef MUX_N_PIPE_XFER_CNT_EN
    ,
    output logic [15:0]             xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nx_s;
    logic signed [WIDTH-1:0]   out_data_r;
    logic signed [WIDTH-1:0]   skid_r;
    logic                      out_valid_r;
    logic                      in_ready_r;
    logic                      sel_err_r;
    logic [1:0]                occ_r;

    logic [WIDTH-1:0]          val_s;
    logic                      sel_bad_s;
    logic                      accept_s;
    logic                      emit_s;
    logic                      load_out_s;
    logic                      load_out_skid_s;
    logic                      load_skid_s;

    assign accept_s = in_valid && in_ready_r;
    assign emit_s   = out_valid_r && out_ready;

    // Operand select; any select with no matching input yields zero and flags an error.
    always_comb begin
        val_s     = {WIDTH{1'b0}};
        sel_bad_s = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(in_sel) == k) begin
                val_s     = in_data[k*WIDTH +: WIDTH];
                sel_bad_s = 1'b0;
            end else begin
                val_s     = val_s;
                sel_bad_s = sel_bad_s;
            end
        end
    end

    // Occupancy FSM: next state and data-path load strobes.
    always_comb begin
        state_nx_s      = state_r;
        load_out_s      = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    load_out_s = 1'b1;
                    state_nx_s = ONE;
                end else begin
                    state_nx_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && emit_s) begin
                    load_out_s = 1'b1;
                    state_nx_s = ONE;
                end else if (accept_s) begin
                    load_skid_s = 1'b1;
                    state_nx_s  = TWO;
                end else if (emit_s) begin
                    state_nx_s = EMPTY;
                end else begin
                    state_nx_s = ONE;
                end
            end
            TWO: begin
                if (emit_s) begin
                    load_out_skid_s = 1'b1;
                    state_nx_s      = ONE;
                end else begin
                    state_nx_s = TWO;
                end
            end
            default: begin
                state_nx_s = EMPTY;
            end
        endcase
    end

    // State, data and registered status outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            out_data_r  <= {WIDTH{1'b0}};
            skid_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            sel_err_r   <= 1'b0;
            occ_r       <= 2'd0;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s != EMPTY);
            in_ready_r  <= (state_nx_s != TWO);
            occ_r       <= state_nx_s;
            sel_err_r   <= sel_err_r | (accept_s & sel_bad_s);
            if (load_out_s) begin
                out_data_r <= val_s;
            end else if (load_out_skid_s) begin
                out_data_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= val_s;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign sel_err   = sel_err_r;
    assign occ       = occ_r;

`ifdef MUX_N_PIPE_XFER_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Saturating count of output transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_r <= 16'd0;
        end else if (emit_s && (xfer_cnt_r != 16'hFFFF)) begin
            xfer_cnt_r <= xfer_cnt_r + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe (WIDTH=64, N=3). Expected output words are
// pushed to a queue when an input transfer is accepted and popped when an output
// transfer happens; scenario tasks also check status outputs inline.
module tb_mux_n_pipe;

    localparam int WIDTH = 64;
    localparam int N     = 3;

    logic                    clk;
    logic                    rst_n;
    logic [N*WIDTH-1:0]      in_data;
    logic [1:0]              in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [1:0]              occ;
`ifdef MUX_N_PIPE_XFER_CNT_EN
    logic [15:0]             xfer_cnt;
`endif

    int n_vec;
    int n_miscmp;
    logic [WIDTH-1:0] sb_q[$];

    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;

    mux_n_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .occ      (occ)
`ifdef MUX_N_PIPE_XFER_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference selection: fixed slice per select code, zero otherwise.
    function automatic logic [WIDTH-1:0] model(input logic [N*WIDTH-1:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return d[63:0];
            2'd1:    return d[127:64];
            2'd2:    return d[191:128];
            default: return 64'd0;
        endcase
    endfunction

    // Advance one clock; scoreboard bookkeeping happens on the falling edge
    // with the transfer conditions that the coming rising edge will act on.
    task automatic step();
        logic [WIDTH-1:0] exp_v;
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            sb_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miscmp++;
                    $display("FAIL sb_unexpected_output: got %0d, expected no output", out_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (out_data !== exp_v) begin
                        n_miscmp++;
                        $display("FAIL sb_data: got %0d, expected %0d", out_data, $signed(exp_v));
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb_q.push_back(model(in_data, in_sel));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 10 && occ !== 2'd0; i++) step();
        n_vec++;
        if (occ !== 2'd0 || sb_q.size() != 0) begin
            n_miscmp++;
            $display("FAIL %s_drain: occ=%0d queue=%0d, expected 0 and 0", name, occ, sb_q.size());
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        out_ready = 1'b1;
        in_data   = {x2, x1, x0};
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 64'd0 ||
                occ !== 2'd0 || sel_err !== 1'b0) begin
                n_miscmp++;
                $display("FAIL reset_hold: v=%b r=%b d=%0d occ=%0d err=%b, expected 0 0 0 0 0",
                         out_valid, in_ready, out_data, occ, sel_err);
            end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || occ !== 2'd0 || out_data !== 64'd0) begin
            n_miscmp++;
            $display("FAIL reset_release: r=%b v=%b occ=%0d d=%0d, expected 1 0 0 0",
                     in_ready, out_valid, occ, out_data);
        end
    endtask

    task automatic test_stream();
        logic [1:0]       sels[3];
        logic [WIDTH-1:0] exps[3];
        sels = '{2'd2, 2'd1, 2'd0};
        exps = '{64'd3, -64'sd2, 64'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sel   = sels[i];
            step();
            n_vec++;
            if (out_valid !== 1'b1 || occ !== 2'd1 || out_data !== exps[i]) begin
                n_miscmp++;
                $display("FAIL stream_%0d: v=%b occ=%0d d=%0d, expected 1 1 %0d",
                         i, out_valid, occ, out_data, $signed(exps[i]));
            end
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== 64'd1) begin
            n_miscmp++;
            $display("FAIL stream_empty: v=%b occ=%0d d=%0d, expected 0 0 1", out_valid, occ, out_data);
        end
        drain("stream");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        n_vec++;
        if (occ !== 2'd1 || in_ready !== 1'b1 || out_data !== 64'd1) begin
            n_miscmp++;
            $display("FAIL bp_one: occ=%0d r=%b d=%0d, expected 1 1 1", occ, in_ready, out_data);
        end
        in_sel = 2'd1;
        step();
        in_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (occ !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'd1) begin
                n_miscmp++;
                $display("FAIL bp_full_%0d: occ=%0d r=%b v=%b d=%0d, expected 2 0 1 1",
                         i, occ, in_ready, out_valid, out_data);
            end
            if (i < 2) step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        n_vec++;
        if (occ !== 2'd1 || out_data !== -64'sd2) begin
            n_miscmp++;
            $display("FAIL bp_release: occ=%0d d=%0d, expected 1 -2", occ, out_data);
        end
        step();
        n_vec++;
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            n_miscmp++;
            $display("FAIL bp_empty: occ=%0d v=%b, expected 0 0", occ, out_valid);
        end
        drain("bp");
    endtask

    task automatic test_sel_err();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        step();
        n_vec++;
        if (out_data !== 64'd0 || sel_err !== 1'b1 || out_valid !== 1'b1) begin
            n_miscmp++;
            $display("FAIL oor_sel: d=%0d err=%b v=%b, expected 0 1 1", out_data, sel_err, out_valid);
        end
        in_sel = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        n_vec++;
        if (sel_err !== 1'b1) begin
            n_miscmp++;
            $display("FAIL oor_sticky: err=%b, expected 1", sel_err);
        end
        drain("oor");
        do_reset(1);
        n_vec++;
        if (sel_err !== 1'b0) begin
            n_miscmp++;
            $display("FAIL oor_clear: err=%b, expected 0", sel_err);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        step();
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (occ !== 2'd2) begin
            n_miscmp++;
            $display("FAIL mid_fill: occ=%0d, expected 2", occ);
        end
        rst_n = 1'b0;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b0) begin
            n_miscmp++;
            $display("FAIL mid_reset: v=%b occ=%0d r=%b, expected 0 0 0", out_valid, occ, in_ready);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_miscmp++;
                $display("FAIL mid_after_%0d: v=%b r=%b, expected 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic             hold_p;
        logic [WIDTH-1:0] data_p;
        logic             rdy;
        hold_p = 1'b0;
        data_p = 64'd0;
        for (int i = 0; i < 300; i++) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_sel   = 2'($urandom_range(2, 0));
            in_valid = ($urandom_range(3, 0) != 0);
            rdy      = ($urandom_range(2, 0) != 0);
            out_ready = rdy;
            hold_p = out_valid && !rdy;
            data_p = out_data;
            step();
            if (hold_p) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== data_p) begin
                    n_miscmp++;
                    $display("FAIL b2b_stable_%0d: v=%b d=%0d, expected 1 %0d",
                             i, out_valid, out_data, $signed(data_p));
                end
            end
        end
        drain("b2b");
    endtask

`ifdef MUX_N_PIPE_XFER_CNT_EN
    task automatic test_xfer_cnt();
        do_reset(1);
        out_ready = 1'b1;
        in_data   = {x2, x1, x0};
        in_sel    = 2'd1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) step();
        drain("cnt");
        n_vec++;
        if (xfer_cnt !== 16'd5) begin
            n_miscmp++;
            $display("FAIL cnt_five: got %0d, expected 5", xfer_cnt);
        end
        force dut.xfer_cnt_r = 16'hFFFF;
        step();
        release dut.xfer_cnt_r;
        in_valid = 1'b1;
        step();
        drain("cnt_sat");
        n_vec++;
        if (xfer_cnt !== 16'hFFFF) begin
            n_miscmp++;
            $display("FAIL cnt_sat: got %h, expected ffff", xfer_cnt);
        end
    endtask
`endif

    initial begin
        n_vec     = 0;
        n_miscmp  = 0;
        x0        = 64'd1;
        x1        = -64'sd2;
        x2        = 64'd3;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        out_ready = 1'b0;
        in_data   = {x2, x1, x0};

        test_reset();
        test_stream();
        test_backpressure();
        in_data = {x2, x1, x0};
        test_sel_err();
        test_reset_mid();
        test_back_to_back();
`ifdef MUX_N_PIPE_XFER_CNT_EN
        test_xfer_cnt();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
